// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: token/count widths and occupancy states shared by the stream FIFO link
package stream_fifo_pkg;
    localparam int TOKEN_W = 16;
    localparam int COUNT_W = 16;
    typedef enum logic [1:0] {EMPTY = 2'd0, PARTIAL = 2'd1, FULL = 2'd2} link_state_e;
endpackage

// File: rtl/stream_fifo_link_if.sv
// stream_fifo_link_if: producer-side write handshake and consumer-side read handshake of the link
interface stream_fifo_link_if #(
    parameter int WIDTH = stream_fifo_pkg::TOKEN_W
);
    logic [WIDTH-1:0]                   WR_DATA;
    logic                               WR_SEND;
    logic [stream_fifo_pkg::COUNT_W-1:0] WR_COUNT;
    logic                               WR_RDY;
    logic                               WR_ACK;
    logic [WIDTH-1:0]                   RD_DATA;
    logic                               RD_SEND;
    logic [stream_fifo_pkg::COUNT_W-1:0] RD_COUNT;
    logic                               RD_ACK;
    modport master (
        output WR_DATA, WR_SEND, WR_COUNT, RD_ACK,
        input  WR_RDY, WR_ACK, RD_DATA, RD_SEND, RD_COUNT
    );
    modport slave (
        input  WR_DATA, WR_SEND, WR_COUNT, RD_ACK,
        output WR_RDY, WR_ACK, RD_DATA, RD_SEND, RD_COUNT
    );
endinterface

// File: rtl/stream_fifo_mem.sv
// stream_fifo_mem: DEPTH x WIDTH token store, one synchronous write port, asynchronous read
module stream_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/stream_fifo_link.sv
// stream_fifo_link: FWFT token FIFO between producer and consumer; STREAM_FIFO_LINK_STATUS_EN adds sticky OVERFLOW/UNDERFLOW
module stream_fifo_link import stream_fifo_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int WIDTH = TOKEN_W
) (
    input  logic CLK,
    input  logic RESET,
`ifdef STREAM_FIFO_LINK_STATUS_EN
    output logic OVERFLOW,
    output logic UNDERFLOW,
`endif
    stream_fifo_link_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    link_state_e      state_q, state_d;
    logic             wr_rdy_q, wr_rdy_d;
    logic             wr_en, rd_en, rd_send, wr_drop, rd_drop;
    logic [WIDTH-1:0] head;
    logic             unused_count;

    assign rd_send = state_q != EMPTY;
    assign wr_en   = bus.WR_SEND & wr_rdy_q;
    assign rd_en   = bus.RD_ACK & rd_send;
    assign wr_drop = bus.WR_SEND & ~wr_rdy_q;
    assign rd_drop = bus.RD_ACK & ~rd_send;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        state_d  = count_d == '0 ? EMPTY : count_d == FULL_CNT ? FULL : PARTIAL;
        wr_rdy_d = count_d != FULL_CNT;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= EMPTY;
            wr_rdy_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            wr_rdy_q <= wr_rdy_d;
        end
    end

    stream_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
        .clk_i   (CLK),
        .we_i    (wr_en & ~RESET),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.WR_DATA),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // storage is never cleared, so the head is masked while the link is empty
    assign bus.RD_DATA  = rd_send ? head : '0;
    assign bus.RD_SEND  = rd_send;
    assign bus.RD_COUNT = COUNT_W'(count_q);
    assign bus.WR_RDY   = wr_rdy_q;
    assign bus.WR_ACK   = wr_en;
    assign unused_count = ^bus.WR_COUNT;

`ifdef STREAM_FIFO_LINK_STATUS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | wr_drop;
            underflow_q <= underflow_q | rd_drop;
        end
    end

    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;
`else
    logic unused_drop;
    assign unused_drop = wr_drop ^ rd_drop;
`endif
endmodule

// File: tb/tb_stream_fifo_link.sv
// tb_stream_fifo_link: queue-model checker plus directed literal checks for stream_fifo_link at DEPTH=4
module tb_stream_fifo_link;
    localparam int D = 4;

    logic CLK = 1'b0;
    logic RESET;
`ifdef STREAM_FIFO_LINK_STATUS_EN
    logic OVERFLOW, UNDERFLOW;
`endif
    stream_fifo_link_if #(.WIDTH(16)) bus ();

    stream_fifo_link #(.DEPTH(D), .WIDTH(16)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
`ifdef STREAM_FIFO_LINK_STATUS_EN
        .OVERFLOW  (OVERFLOW),
        .UNDERFLOW (UNDERFLOW),
`endif
        .bus       (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 0;
    logic [15:0] mq[$];
    bit m_ovf, m_unf, acc, pop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ws, input logic [15:0] wd, input logic ra);
        bus.WR_SEND  = ws;
        bus.WR_DATA  = wd;
        bus.RD_ACK   = ra;
        bus.WR_COUNT = 16'd0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(posedge CLK) begin
        if (RESET) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            acc = bus.WR_SEND && mq.size() < D;
            pop = bus.RD_ACK && mq.size() > 0;
            if (bus.WR_SEND && !acc) m_ovf = 1;
            if (bus.RD_ACK && !pop) m_unf = 1;
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(bus.WR_DATA);
        end
    end

    always @(negedge CLK) begin
        if (checking) begin
            check("m_rd_send", bus.RD_SEND, mq.size() != 0);
            check("m_rd_count", bus.RD_COUNT, mq.size());
            check("m_rd_data", bus.RD_DATA, mq.size() != 0 ? mq[0] : 16'h0);
            check("m_wr_rdy", bus.WR_RDY, mq.size() != D);
            check("m_wr_ack", bus.WR_ACK, bus.WR_SEND && mq.size() != D);
`ifdef STREAM_FIFO_LINK_STATUS_EN
            check("m_overflow", OVERFLOW, m_ovf);
            check("m_underflow", UNDERFLOW, m_unf);
`endif
        end
    end

    initial begin
        int nexp;
        int max_cnt;
        RESET = 1'b1;
        drive(0, 16'h0, 0);
        tick();
        tick();
        RESET = 1'b0;
        checking = 1;
        check("rst_rd_send", bus.RD_SEND, 0);
        check("rst_rd_count", bus.RD_COUNT, 0);
        check("rst_wr_rdy", bus.WR_RDY, 1);
        check("rst_wr_ack", bus.WR_ACK, 0);
        check("rst_rd_data", bus.RD_DATA, 0);

        drive(1, 16'h0011, 0);
        tick();
        drive(0, 16'h0, 0);
        #1;
        check("lat_rd_send", bus.RD_SEND, 1);
        check("lat_rd_data", bus.RD_DATA, 16'h0011);
        check("lat_rd_count", bus.RD_COUNT, 1);
        tick();
        drive(0, 16'h0, 1);
        tick();

        for (int i = 0; i < 4; i++) begin
            drive(1, 16'hA000 + 16'(i), 0);
            tick();
        end
        drive(0, 16'h0, 0);
        #1;
        check("full_wr_rdy", bus.WR_RDY, 0);
        check("full_count", bus.RD_COUNT, 4);
        drive(1, 16'hBEEF, 0);
        #1;
        check("ovf_wr_ack", bus.WR_ACK, 0);
        tick();
        drive(0, 16'h0, 0);
        #1;
        check("ovf_count", bus.RD_COUNT, 4);
        check("ovf_head", bus.RD_DATA, 16'hA000);
`ifdef STREAM_FIFO_LINK_STATUS_EN
        check("ovf_flag", OVERFLOW, 1);
        check("ovf_unf_flag", UNDERFLOW, 0);
`endif
        drive(1, 16'hDEAD, 1);
        #1;
        check("fullpop_wr_rdy", bus.WR_RDY, 0);
        check("fullpop_wr_ack", bus.WR_ACK, 0);
        check("pop0", bus.RD_DATA, 16'hA000);
        tick();
        for (int i = 1; i < 4; i++) begin
            drive(0, 16'h0, 1);
            #1;
            check("pop_seq", bus.RD_DATA, 16'hA000 + 32'(i));
            tick();
        end
        drive(0, 16'h0, 0);
        #1;
        check("drained_rd_send", bus.RD_SEND, 0);

        drive(1, 16'h0101, 0);
        tick();
        drive(1, 16'h0202, 0);
        tick();
        drive(1, 16'h0C0C, 1);
        #1;
        check("sim_head", bus.RD_DATA, 16'h0101);
        tick();
        drive(0, 16'h0, 0);
        #1;
        check("sim_count", bus.RD_COUNT, 2);
        check("sim_head2", bus.RD_DATA, 16'h0202);
        drive(0, 16'h0, 1);
        tick();
        drive(0, 16'h0, 0);
        #1;
        check("sim_order", bus.RD_DATA, 16'h0C0C);
        drive(0, 16'h0, 1);
        tick();

        drive(0, 16'h0, 1);
        tick();
        drive(0, 16'h0, 0);
        #1;
        check("unf_count", bus.RD_COUNT, 0);
`ifdef STREAM_FIFO_LINK_STATUS_EN
        check("unf_flag", UNDERFLOW, 1);
`endif

        nexp = 0;
        max_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            drive(i < 10, 16'h5000 + 16'(i), 1);
            #1;
            if (bus.RD_SEND) begin
                check("stream", bus.RD_DATA, 16'h5000 + 32'(nexp));
                nexp++;
            end
            if (int'(bus.RD_COUNT) > max_cnt) max_cnt = int'(bus.RD_COUNT);
            tick();
        end
        check("stream_total", nexp, 10);
        check("stream_max_le_4", max_cnt <= 4, 1);

        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0));
            tick();
        end

        drive(0, 16'h0, 1);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'h3000 + 16'(i), 0);
            tick();
        end
        RESET = 1'b1;
        drive(1, 16'h7777, 0);
        tick();
        RESET = 1'b0;
        drive(0, 16'h0, 0);
        #1;
        check("mid_rst_count", bus.RD_COUNT, 0);
        check("mid_rst_rd_send", bus.RD_SEND, 0);
        check("mid_rst_wr_rdy", bus.WR_RDY, 1);
        check("mid_rst_rd_data", bus.RD_DATA, 0);
`ifdef STREAM_FIFO_LINK_STATUS_EN
        check("mid_rst_ovf", OVERFLOW, 0);
        check("mid_rst_unf", UNDERFLOW, 0);
`endif
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stream_fifo_link.md
STREAM_FIFO_LINK -- requirements
Module: stream_fifo_link

Interface
REQ-001 SHALL have parameter DEPTH, default 16, token capacity; power of two, 2..1024.
REQ-002 SHALL have parameter WIDTH, default 16, token width in bits.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-005 SHALL have port WR_DATA, input, WIDTH, token from the producer's Out DATA.
REQ-006 SHALL have port WR_SEND, input, 1, producer write strobe: one token per cycle.
REQ-007 SHALL have port WR_COUNT, input, 16, producer token count; ignored.
REQ-008 SHALL have port WR_RDY, output, 1, space available; drives the producer's Out RDY.
REQ-009 SHALL have port WR_ACK, output, 1, write accepted this cycle; drives the producer's Out ACK.
REQ-010 SHALL have port RD_DATA, output, WIDTH, head token; drives the consumer's In DATA.
REQ-011 SHALL have port RD_SEND, output, 1, token available; drives the consumer's In SEND.
REQ-012 SHALL have port RD_COUNT, output, 16, occupancy zero-extended; drives the consumer's In COUNT.
REQ-013 SHALL have port RD_ACK, input, 1, consumer pop strobe: one token per cycle.

Function
REQ-014 SHALL store tokens in arrival order and present them first-word-fall-through: RD_DATA valid whenever RD_SEND=1, with no extra read cycle.
REQ-015 SHALL accept a write when WR_SEND=1 and WR_RDY=1; WR_ACK SHALL equal WR_SEND & WR_RDY combinationally.
REQ-016 SHALL raise RD_SEND and RD_COUNT one cycle after an accepted write into an empty link (write-to-read latency 1).
REQ-017 SHALL pop the head token on RD_ACK=1 with RD_SEND=1; the next token SHALL appear on RD_DATA in the following cycle.
REQ-018 SHALL drive WR_RDY=0 when occupancy equals DEPTH and WR_RDY=1 otherwise, registered from occupancy.
REQ-019 SHALL, when full and RD_ACK=1, still hold WR_RDY=0 in that cycle; no write is accepted.
REQ-020 SHALL, on simultaneous accepted write and pop with occupancy 1..DEPTH-1, leave occupancy unchanged and keep order.
REQ-021 SHALL drop WR_SEND while WR_RDY=0, with no state change and WR_ACK=0.
REQ-022 SHALL ignore RD_ACK while RD_SEND=0, with no state change.
REQ-023 SHALL use read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0, and an occupancy counter of log2(DEPTH)+1 bits.
REQ-024 SHALL keep the occupancy state EMPTY/PARTIAL/FULL: EMPTY->PARTIAL on write; PARTIAL->FULL on write-only at DEPTH-1; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop-only at 1.

Reset
REQ-025 SHALL, while RESET=1 at a clock edge, clear pointers and occupancy and set state EMPTY.
REQ-026 SHALL drive these values in the cycle after reset: RD_SEND=0, RD_COUNT=0, WR_RDY=1, WR_ACK=0, and RD_DATA=0.
REQ-027 SHALL discard stored tokens on reset mid-operation; writes and pops in a reset cycle SHALL have no effect.

Configuration
REQ-028 SHALL, with STREAM_FIFO_LINK_STATUS_EN defined, add output OVERFLOW (1) and output UNDERFLOW (1). Each is sticky and set the cycle after a dropped write (REQ-021) or an ignored pop (REQ-022). Both are cleared only by RESET and are 0 after reset.
REQ-029 SHALL, without STREAM_FIFO_LINK_STATUS_EN, omit both ports and all their logic; the behaviour defined above is otherwise identical.

Structure
REQ-030 SHALL take TOKEN_W=16, COUNT_W=16 and the EMPTY/PARTIAL/FULL state enumeration from shared package stream_fifo_pkg.
REQ-031 SHALL place token storage in one sub-module, stream_fifo_mem: DEPTH x WIDTH, one write port, asynchronous read at the read pointer.

Verification (DEPTH=4, WIDTH=16)
REQ-032 Write 0x0011 in cycle 0 into an empty link, RD_ACK=0 -> in cycle 1 RD_SEND=1, RD_DATA=0x0011, RD_COUNT=1.
REQ-033 Write 0xA000..0xA003, then pop 4 -> popped data in order A000..A003; WR_RDY=0 after the 4th write; RD_SEND=0 after the last pop.
REQ-034 Full link, WR_SEND with 0xBEEF -> WR_ACK=0, contents unchanged; OVERFLOW=1 next cycle if the macro is enabled.
REQ-035 Occupancy 2, simultaneous write 0x0C0C and pop -> RD_COUNT stays 2; 0x0C0C emerges after the older token.
REQ-036 Stream 10 tokens with continuous pop -> pointers wrap; data sequence intact; RD_COUNT never exceeds 4.
REQ-037 Occupancy 3, RESET pulse with concurrent WR_SEND -> next cycle RD_COUNT=0, RD_SEND=0, WR_RDY=1.
